// File: rtl/one_wire_master_tx_pkg.sv
// Shared types and default timing (cycles at 100 MHz) for the 1-Wire master transmitter.
package one_wire_pkg;

    localparam int unsigned CNT_W = 16;

    localparam int unsigned T_RSTL_DEF = 48000;
    localparam int unsigned T_PDS_DEF  = 7000;
    localparam int unsigned T_RSTH_DEF = 48000;
    localparam int unsigned T_LOW1_DEF = 600;
    localparam int unsigned T_SLOT_DEF = 6000;
    localparam int unsigned T_REC_DEF  = 100;
    localparam int unsigned T_RD_DEF   = 1500;

    typedef logic [CNT_W-1:0] cnt_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RST_LOW,
        ST_RST_HIGH,
        ST_SLOT_LOW,
        ST_SLOT_HIGH,
        ST_SLOT_REC
    } state_t;

endpackage

// File: rtl/one_wire_master_tx_if.sv
// Host-side request/status handshake of the 1-Wire master transmitter.
interface one_wire_master_tx_if;
    logic       enable;
    logic       reset_req;
    logic       tx_start;
    logic [7:0] tx_byte;
    logic       busy;
    logic       done;
    logic       presence_detect;
    logic       bit_err;

    modport master (
        output enable, reset_req, tx_start, tx_byte,
        input  busy, done, presence_detect, bit_err
    );

    modport slave (
        input  enable, reset_req, tx_start, tx_byte,
        output busy, done, presence_detect, bit_err
    );
endinterface

// File: rtl/one_wire_sync.sv
// Two-flop synchronizer for the open-drain bus input; resets to the released (1) level.
module one_wire_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);
    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;
endmodule

// File: rtl/one_wire_master_tx.sv
// 1-Wire master: reset/presence sequences and MSB-first byte write slots on an open-drain line.
// Defining ONE_WIRE_TX_READBACK_EN adds readback checking of write-1 slots (bit_err).
module one_wire_master_tx
    import one_wire_pkg::*;
#(
    parameter int unsigned T_RSTL = T_RSTL_DEF,
    parameter int unsigned T_PDS  = T_PDS_DEF,
    parameter int unsigned T_RSTH = T_RSTH_DEF,
    parameter int unsigned T_LOW1 = T_LOW1_DEF,
    parameter int unsigned T_SLOT = T_SLOT_DEF,
    parameter int unsigned T_REC  = T_REC_DEF
`ifdef ONE_WIRE_TX_READBACK_EN
    ,
    parameter int unsigned T_RD   = T_RD_DEF
`endif
) (
    input  logic                clk,
    input  logic                rst_n,
    one_wire_master_tx_if.slave ctrl,
    inout  wire                 one_wire_data
);
    localparam cnt_t RSTL_END = cnt_t'(T_RSTL - 1);
    localparam cnt_t RSTH_END = cnt_t'(T_RSTH - 1);
    localparam cnt_t PDS_PT   = cnt_t'(T_PDS);
    localparam cnt_t LOW1_END = cnt_t'(T_LOW1 - 1);
    localparam cnt_t LOW1_LEN = cnt_t'(T_LOW1);
    localparam cnt_t SLOT_END = cnt_t'(T_SLOT - 1);
    localparam cnt_t REC_END  = cnt_t'(T_REC - 1);
`ifdef ONE_WIRE_TX_READBACK_EN
    localparam cnt_t RD_PT    = cnt_t'(T_RD);
`endif

    state_t     state_q, state_d;
    cnt_t       cnt_q, cnt_d;
    logic [7:0] shift_q, shift_d;
    logic [2:0] bit_q, bit_d;
    logic       drive_q, drive_d;
    logic       done_q, done_d;
    logic       pres_q, pres_d;
    logic       line_s;
`ifdef ONE_WIRE_TX_READBACK_EN
    logic       err_q, err_d;
`endif

    one_wire_sync u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (one_wire_data),
        .q_o   (line_s)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + cnt_t'(1);
        shift_d = shift_q;
        bit_d   = bit_q;
        done_d  = 1'b0;
        pres_d  = pres_q;
`ifdef ONE_WIRE_TX_READBACK_EN
        err_d   = err_q;
`endif
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (ctrl.enable && ctrl.reset_req) begin
                    state_d = ST_RST_LOW;
                end else if (ctrl.enable && ctrl.tx_start) begin
                    state_d = ST_SLOT_LOW;
                    shift_d = ctrl.tx_byte;
                    bit_d   = 3'd7;
                end
`ifdef ONE_WIRE_TX_READBACK_EN
                if (state_d != ST_IDLE) err_d = 1'b0;
`endif
            end
            ST_RST_LOW: begin
                if (cnt_q == RSTL_END) begin
                    state_d = ST_RST_HIGH;
                    cnt_d   = '0;
                end
            end
            ST_RST_HIGH: begin
                if (cnt_q == PDS_PT) pres_d = ~line_s;
                if (cnt_q == RSTH_END) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            ST_SLOT_LOW: begin
                if (shift_q[7] && cnt_q == LOW1_END) begin
                    state_d = ST_SLOT_HIGH;
                    // keep counting slot time so the high phase ends at T_SLOT from slot start
                    cnt_d   = LOW1_LEN;
                end else if (!shift_q[7] && cnt_q == SLOT_END) begin
                    state_d = ST_SLOT_REC;
                    cnt_d   = '0;
                end
            end
            ST_SLOT_HIGH: begin
`ifdef ONE_WIRE_TX_READBACK_EN
                if (cnt_q == RD_PT && !line_s) err_d = 1'b1;
`endif
                if (cnt_q == SLOT_END) begin
                    state_d = ST_SLOT_REC;
                    cnt_d   = '0;
                end
            end
            ST_SLOT_REC: begin
                if (cnt_q == REC_END) begin
                    cnt_d = '0;
                    if (bit_q == 3'd0) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_SLOT_LOW;
                        bit_d   = bit_q - 3'd1;
                        shift_d = {shift_q[6:0], 1'b0};
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // enable low aborts silently, keeping the last presence result
        if (!ctrl.enable) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            done_d  = 1'b0;
            pres_d  = pres_q;
`ifdef ONE_WIRE_TX_READBACK_EN
            err_d   = err_q;
`endif
        end

        drive_d = (state_d == ST_RST_LOW) || (state_d == ST_SLOT_LOW);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            shift_q <= '0;
            bit_q   <= '0;
            drive_q <= 1'b0;
            done_q  <= 1'b0;
            pres_q  <= 1'b0;
`ifdef ONE_WIRE_TX_READBACK_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            bit_q   <= bit_d;
            drive_q <= drive_d;
            done_q  <= done_d;
            pres_q  <= pres_d;
`ifdef ONE_WIRE_TX_READBACK_EN
            err_q   <= err_d;
`endif
        end
    end

    assign one_wire_data        = drive_q ? 1'b0 : 1'bz;
    assign ctrl.busy            = (state_q != ST_IDLE);
    assign ctrl.done            = done_q;
    assign ctrl.presence_detect = pres_q;
`ifdef ONE_WIRE_TX_READBACK_EN
    assign ctrl.bit_err         = err_q;
`else
    assign ctrl.bit_err         = 1'b0;
`endif
endmodule

// File: tb/tb_one_wire_master_tx.sv
// Directed bench for one_wire_master_tx with timing scaled to 1 cycle per microsecond.
// Readback cases are built only when ONE_WIRE_TX_READBACK_EN is defined.
module tb_one_wire_master_tx;
    localparam int unsigned P_RSTL = 480;
    localparam int unsigned P_PDS  = 70;
    localparam int unsigned P_RSTH = 480;
    localparam int unsigned P_LOW1 = 6;
    localparam int unsigned P_SLOT = 60;
    localparam int unsigned P_REC  = 1;
`ifdef ONE_WIRE_TX_READBACK_EN
    localparam int unsigned P_RD   = 15;
`endif

    typedef struct {
        logic       do_rst;
        logic       do_tx;
        logic [7:0] tx_byte;
        logic       slave;
        logic       exp_pres;
        int         exp_lat;
        int         exp_w0;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic slave_low = 1'b0;
    wire  one_wire_data;

    int vec_cnt = 0;
    int miss_cnt = 0;
    int widths[$];
    int starts[$];
    vec_t vecs[7];

    pullup (one_wire_data);
    assign one_wire_data = slave_low ? 1'b0 : 1'bz;

    one_wire_master_tx_if ctrl_if ();

    one_wire_master_tx #(
        .T_RSTL (P_RSTL),
        .T_PDS  (P_PDS),
        .T_RSTH (P_RSTH),
        .T_LOW1 (P_LOW1),
        .T_SLOT (P_SLOT),
        .T_REC  (P_REC)
`ifdef ONE_WIRE_TX_READBACK_EN
        ,
        .T_RD   (P_RD)
`endif
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ctrl          (ctrl_if),
        .one_wire_data (one_wire_data)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            miss_cnt++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Issues one request and follows the line until done (bounded), recording low pulses.
    task automatic run_op(input string tag, input logic do_rst, input logic do_tx,
                          input logic [7:0] b, input logic slave,
                          input int inj_at, input logic inj_rst, input logic inj_tx,
                          input int pull_from, input int pull_to, output int lat);
        int   cnt = 0;
        int   cur = 0;
        int   rel = 0;
        logic prev_low = 1'b0;
        logic released = 1'b0;
        logic line_low;
        logic pres_pull;
        widths.delete();
        starts.delete();
        lat = -1;
        @(negedge clk);
        ctrl_if.reset_req = do_rst;
        ctrl_if.tx_start  = do_tx;
        ctrl_if.tx_byte   = b;
        @(posedge clk);
        #1;
        ctrl_if.reset_req = 1'b0;
        ctrl_if.tx_start  = 1'b0;
        while (cnt < 3000) begin
            @(negedge clk);
            cnt++;
            line_low = (one_wire_data === 1'b0);
            if (cnt == 1) begin
                check({tag, "/busy_after_accept"}, ctrl_if.busy, 1);
                check({tag, "/line_low_after_accept"}, line_low, 1);
            end
            if (line_low && !prev_low) starts.push_back(cnt);
            if (line_low) cur++;
            else if (prev_low) begin
                widths.push_back(cur);
                cur = 0;
                if (!released) begin
                    released = 1'b1;
                    rel = cnt;
                end
            end
            prev_low = line_low;
            pres_pull = slave && released && (cnt >= rel + 15) && (cnt < rel + 240);
            slave_low = pres_pull || ((cnt >= pull_from) && (cnt < pull_to));
            if (inj_at != 0 && cnt == inj_at) begin
                ctrl_if.reset_req = inj_rst;
                ctrl_if.tx_start  = inj_tx;
                ctrl_if.tx_byte   = 8'hFF;
            end else if (inj_at != 0 && cnt == inj_at + 1) begin
                ctrl_if.reset_req = 1'b0;
                ctrl_if.tx_start  = 1'b0;
            end
            if (ctrl_if.done) begin
                lat = cnt;
                check({tag, "/busy_low_at_done"}, ctrl_if.busy, 0);
                break;
            end
        end
        slave_low = 1'b0;
        check({tag, "/done_seen"}, lat >= 0, 1);
        @(negedge clk);
        check({tag, "/done_one_cycle"}, ctrl_if.done, 0);
    endtask

    task automatic check_byte(input string tag, input logic [7:0] exp);
        logic [7:0] rx = '0;
        int wbad = 0;
        int pbad = 0;
        check({tag, "/nbits"}, widths.size(), 8);
        for (int i = 0; i < 8 && i < widths.size(); i++) begin
            rx = {rx[6:0], widths[i] < 30};
            if (widths[i] != (exp[7-i] ? 6 : 60)) wbad++;
        end
        for (int i = 1; i < starts.size(); i++)
            if (starts[i] - starts[i-1] != 61) pbad++;
        check({tag, "/rx_byte"}, rx, exp);
        check({tag, "/low_width_errs"}, wbad, 0);
        check({tag, "/slot_period_errs"}, pbad, 0);
    endtask

    task automatic idle_check(input string tag, input int n);
        int bad = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (ctrl_if.busy || ctrl_if.done || one_wire_data === 1'b0) bad++;
        end
        check({tag, "/idle_errs"}, bad, 0);
    endtask

    initial begin
        int lat;
        int bad;
        vecs[0] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 961, 480};
        vecs[1] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 961, 480};
        vecs[2] = '{1'b0, 1'b1, 8'hA5, 1'b0, 1'b0, 489, 6};
        vecs[3] = '{1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 489, 60};
        vecs[4] = '{1'b0, 1'b1, 8'hFF, 1'b0, 1'b0, 489, 6};
        vecs[5] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 961, 480};
        vecs[6] = '{1'b0, 1'b1, 8'h5A, 1'b0, 1'b1, 489, 60};

        ctrl_if.enable    = 1'b1;
        ctrl_if.reset_req = 1'b0;
        ctrl_if.tx_start  = 1'b0;
        ctrl_if.tx_byte   = 8'h00;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst/busy", ctrl_if.busy, 0);
        check("rst/done", ctrl_if.done, 0);
        check("rst/presence", ctrl_if.presence_detect, 0);
        check("rst/bit_err", ctrl_if.bit_err, 0);
        check("rst/line", one_wire_data, 1);

        for (int v = 0; v < 7; v++) begin
            run_op("vec", vecs[v].do_rst, vecs[v].do_tx, vecs[v].tx_byte, vecs[v].slave,
                   0, 1'b0, 1'b0, 0, 0, lat);
            check("vec/latency", lat, vecs[v].exp_lat);
            check("vec/first_low_width", widths.size() > 0 ? widths[0] : -1, vecs[v].exp_w0);
            check("vec/presence", ctrl_if.presence_detect, vecs[v].exp_pres);
            check("vec/bit_err", ctrl_if.bit_err, 0);
            if (vecs[v].do_tx) check_byte("vec", vecs[v].tx_byte);
        end

        // Requests while busy are dropped, not queued.
        run_op("busy_ign", 1'b0, 1'b1, 8'hA5, 1'b0, 100, 1'b1, 1'b1, 0, 0, lat);
        check("busy_ign/latency", lat, 489);
        check_byte("busy_ign", 8'hA5);
        idle_check("busy_ign", 20);

        // Simultaneous reset_req and tx_start: reset wins, write dropped.
        run_op("both", 1'b1, 1'b1, 8'h00, 1'b0, 0, 1'b0, 1'b0, 0, 0, lat);
        check("both/latency", lat, 961);
        check("both/first_low_width", widths.size() > 0 ? widths[0] : -1, 480);
        check("both/npulses", widths.size(), 1);
        check("both/presence", ctrl_if.presence_detect, 0);
        idle_check("both", 20);

        // Abort mid-bit by dropping enable, then a clean 0x3C write.
        @(negedge clk);
        ctrl_if.tx_start = 1'b1;
        ctrl_if.tx_byte  = 8'h3C;
        @(negedge clk);
        ctrl_if.tx_start = 1'b0;
        repeat (69) @(negedge clk);
        check("abort/line_low_before", one_wire_data === 1'b0, 1);
        ctrl_if.enable = 1'b0;
        @(negedge clk);
        check("abort/line_released", one_wire_data, 1);
        check("abort/busy", ctrl_if.busy, 0);
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            ctrl_if.tx_start = (i == 10);
            @(negedge clk);
            if (ctrl_if.busy || ctrl_if.done || one_wire_data === 1'b0) bad++;
        end
        ctrl_if.tx_start = 1'b0;
        check("abort/idle_errs", bad, 0);
        ctrl_if.enable = 1'b1;
        run_op("after_abort", 1'b0, 1'b1, 8'h3C, 1'b0, 0, 1'b0, 1'b0, 0, 0, lat);
        check("after_abort/latency", lat, 489);
        check_byte("after_abort", 8'h3C);

`ifdef ONE_WIRE_TX_READBACK_EN
        run_op("rb_pull", 1'b0, 1'b1, 8'hFF, 1'b0, 0, 1'b0, 1'b0, 1, 21, lat);
        check("rb_pull/bit_err", ctrl_if.bit_err, 1);
        run_op("rb_clean", 1'b0, 1'b1, 8'hFF, 1'b0, 0, 1'b0, 1'b0, 0, 0, lat);
        check("rb_clean/bit_err", ctrl_if.bit_err, 0);
        check_byte("rb_clean", 8'hFF);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end
endmodule
